// File: rtl/inst_buffer_mq_if.sv
// Predecode-to-decode instruction queue bus: enqueue group, dequeue group, flush and status.
// The queue takes the slave view; predecode/decode (or a bench) take the master view.
interface inst_buffer_mq_if #(
  parameter int ENQ_WIDTH = 4,
  parameter int DEQ_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int INST_W    = 32
);
  localparam int NUM_W = $clog2(ENQ_WIDTH) + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                                flush;
  logic [ENQ_WIDTH-1:0]                enq_en;
  logic [NUM_W-1:0]                    enq_num;
  logic [ENQ_WIDTH-1:0][INST_W-1:0]    enq_inst;
  logic                                stall;
  logic                                deq_ready;
  logic [DEQ_WIDTH-1:0]                deq_en;
  logic [DEQ_WIDTH-1:0][INST_W-1:0]    deq_inst;
  logic [CNT_W-1:0]                    count;

  modport master (
    output flush, enq_en, enq_num, enq_inst, deq_ready,
    input  stall, deq_en, deq_inst, count
  );

  modport slave (
    input  flush, enq_en, enq_num, enq_inst, deq_ready,
    output stall, deq_en, deq_inst, count
  );
endinterface

// File: rtl/inst_buffer_mq.sv
// Multi-lane circular instruction queue: up to ENQ_WIDTH in, up to DEQ_WIDTH oldest out per cycle.
// Outputs are combinational from registers (no bypass); stall ignores same-cycle dequeue.
module inst_buffer_mq #(
  parameter int ENQ_WIDTH = 4,
  parameter int DEQ_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int INST_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  inst_buffer_mq_if.slave   io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  occ;
  logic [PTR_W-1:0]  free_slots;
  logic [PTR_W-1:0]  deq_num;
  logic              enq_fire;
  logic              deq_fire;
  logic [INST_W-1:0] mem [DEPTH];

  // The extra wrap bit makes tail - head exact for both empty and full.
  assign occ        = tail - head;
  assign free_slots = PTR_W'(DEPTH) - occ;
  assign deq_num    = (occ > PTR_W'(DEQ_WIDTH)) ? PTR_W'(DEQ_WIDTH) : occ;
  assign enq_fire   = (|io.enq_en) && !io.stall && !io.flush;
  assign deq_fire   = io.deq_ready && !io.flush;

  assign io.count = occ;
  assign io.stall = free_slots < PTR_W'(ENQ_WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (io.flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_fire) tail <= tail + PTR_W'(io.enq_num);
      if (deq_fire) head <= head + deq_num;
    end
  end

  // Storage is not reset; stale entries are never exposed because deq_en tracks occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (enq_fire && io.enq_en[i])
        mem[tail[IDX_W-1:0] + IDX_W'(i)] <= io.enq_inst[i];
    end
  end

  always_comb begin
    io.deq_en   = '0;
    io.deq_inst = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      io.deq_en[i]   = PTR_W'(i) < occ;
      io.deq_inst[i] = mem[head[IDX_W-1:0] + IDX_W'(i)];
    end
  end
endmodule

// File: tb/tb_inst_buffer_mq.sv
// Directed plus randomized bench for inst_buffer_mq against a queue-based reference model.
module tb_inst_buffer_mq;
  localparam int ENQ_WIDTH = 4;
  localparam int DEQ_WIDTH = 4;
  localparam int DEPTH     = 16;
  localparam int INST_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_buffer_mq_if #(
    .ENQ_WIDTH(ENQ_WIDTH), .DEQ_WIDTH(DEQ_WIDTH), .DEPTH(DEPTH), .INST_W(INST_W)
  ) ifc ();

  inst_buffer_mq #(
    .ENQ_WIDTH(ENQ_WIDTH), .DEQ_WIDTH(DEQ_WIDTH), .DEPTH(DEPTH), .INST_W(INST_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  logic [INST_W-1:0] mq [$];
  logic [INST_W-1:0] grp [ENQ_WIDTH];
  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [INST_W-1:0] obs, input logic [INST_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_occ();
    return (mq.size() < DEQ_WIDTH) ? mq.size() : DEQ_WIDTH;
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = min_occ();
    chk({tag, ".count"}, INST_W'(ifc.count), INST_W'(mq.size()));
    chk({tag, ".stall"}, INST_W'(ifc.stall), INST_W'((DEPTH - mq.size()) < ENQ_WIDTH));
    chk({tag, ".deq_en"}, INST_W'(ifc.deq_en), INST_W'((1 << n) - 1));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.deq_inst%0d", tag, i), ifc.deq_inst[i], mq[i]);
  endtask

  // One clock: drive a group, advance the model by the queue's rules, then compare.
  task automatic cycle(input string tag, input bit fl, input int n, input bit rdy, output bit acc);
    int  sz;
    bit  st;
    int  nd;
    sz = mq.size();
    st = (DEPTH - sz) < ENQ_WIDTH;
    ifc.flush     = fl;
    ifc.enq_num   = 3'(n);
    ifc.enq_en    = 4'((1 << n) - 1);
    for (int i = 0; i < ENQ_WIDTH; i++) ifc.enq_inst[i] = grp[i];
    ifc.deq_ready = rdy;
    assert ($countones(ifc.enq_en) == int'(ifc.enq_num) &&
            ((ifc.enq_en & (ifc.enq_en + 4'd1)) == 4'd0))
    else $fatal(1, "FAIL illegal enqueue group en=%b num=%0d", ifc.enq_en, ifc.enq_num);
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (fl) mq.delete();
    else begin
      nd = rdy ? ((sz < DEQ_WIDTH) ? sz : DEQ_WIDTH) : 0;
      repeat (nd) void'(mq.pop_front());
      if (n > 0 && !st) begin
        for (int i = 0; i < n; i++) mq.push_back(grp[i]);
        acc = 1'b1;
      end
    end
    assert (mq.size() <= DEPTH) else $fatal(1, "FAIL model overflow size=%0d", mq.size());
    check_all(tag);
  endtask

  task automatic rand_grp();
    for (int i = 0; i < ENQ_WIDTH; i++) grp[i] = $urandom;
  endtask

  initial begin
    bit acc;
    int seq;
    ifc.flush = 0; ifc.enq_en = '0; ifc.enq_num = '0; ifc.enq_inst = '0; ifc.deq_ready = 0;
    for (int i = 0; i < ENQ_WIDTH; i++) grp[i] = '0;

    // 1: reset, then idle after release
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    cycle("idle", 0, 0, 0, acc);

    // 2: three instructions, no dequeue
    grp[0] = 32'hA000_000A; grp[1] = 32'hB000_000B; grp[2] = 32'hC000_000C; grp[3] = $urandom;
    cycle("enq3", 0, 3, 0, acc);
    chk("enq3.A", ifc.deq_inst[0], 32'hA000_000A);
    chk("enq3.C", ifc.deq_inst[2], 32'hC000_000C);

    // 3: dequeue A..C while enqueuing D..G
    grp[0] = 32'hD000_000D; grp[1] = 32'hE000_000E; grp[2] = 32'hF000_000F; grp[3] = 32'h6000_0006;
    cycle("enqdeq", 0, 4, 1, acc);
    chk("enqdeq.D", ifc.deq_inst[0], 32'hD000_000D);
    chk("enqdeq.G", ifc.deq_inst[3], 32'h6000_0006);

    // 4: fill to 13, stalled enqueue is ignored, dequeue releases stall
    rand_grp(); cycle("fill8", 0, 4, 0, acc);
    rand_grp(); cycle("fill12", 0, 4, 0, acc);
    rand_grp(); cycle("fill13", 0, 1, 0, acc);
    chk("fill13.stall", 32'(ifc.stall), 32'd1);
    rand_grp(); cycle("stalled", 0, 4, 0, acc);
    chk("stalled.count", 32'(ifc.count), 32'd13);
    cycle("deq4", 0, 0, 1, acc);
    chk("deq4.count", 32'(ifc.count), 32'd9);
    chk("deq4.stall", 32'(ifc.stall), 32'd0);

    // 5: streaming across the pointer wrap; a stalled group is held and re-offered
    seq = 32'h5000_0000;
    for (int i = 0; i < ENQ_WIDTH; i++) grp[i] = 32'(seq + i);
    for (int k = 0; k < 40; k++) begin
      cycle("stream", 0, 4, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        seq += ENQ_WIDTH;
        for (int i = 0; i < ENQ_WIDTH; i++) grp[i] = 32'(seq + i);
      end
    end

    // 6: drain, build count=10, flush with a colliding enqueue and dequeue
    for (int k = 0; k < 8 && mq.size() > 0; k++) cycle("drain", 0, 0, 1, acc);
    chk("drain.empty", 32'(ifc.count), 32'd0);
    rand_grp(); cycle("pre10a", 0, 4, 0, acc);
    rand_grp(); cycle("pre10b", 0, 4, 0, acc);
    rand_grp(); cycle("pre10c", 0, 2, 0, acc);
    chk("pre10.count", 32'(ifc.count), 32'd10);
    for (int i = 0; i < ENQ_WIDTH; i++) grp[i] = 32'hDEAD_0000 + 32'(i);
    cycle("flush", 1, 4, 1, acc);
    chk("flush.count", 32'(ifc.count), 32'd0);
    chk("flush.deq_en", 32'(ifc.deq_en), 32'd0);
    cycle("postflush", 0, 0, 1, acc);
    grp[0] = 32'h1234_5678; grp[1] = 32'h9ABC_DEF0; grp[2] = $urandom; grp[3] = $urandom;
    cycle("refill", 0, 2, 0, acc);
    chk("refill.lane0", ifc.deq_inst[0], 32'h1234_5678);

    // Asynchronous reset in the middle of a cycle
    rand_grp(); cycle("prerst", 0, 4, 0, acc);
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    cycle("after_rst", 0, 0, 1, acc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
